// File: rtl/operand_sequencer.sv
// Multi-phase operand selector: on start, steps through NUM_PHASE phases and registers one source per phase.
// Optional sticky illegal-select detection is built only when OPSEQ_SELERR_EN is defined.
module operand_sequencer #(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC   = 8,
   parameter int SEL_W     = 4,
   parameter int NUM_PHASE = 3
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [NUM_PHASE*SEL_W-1:0] sel_vec,
   input  logic [NUM_SRC*WIDTH-1:0]   src_bus,
   input  logic                       stall,
   output logic                       busy,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   output logic [2:0]                 out_phase,
   output logic                       done,
   output logic                       err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                     state_q, state_d;
   logic [2:0]                 phase_q, phase_d;
   logic [NUM_PHASE*SEL_W-1:0] sel_q;
   logic [SEL_W-1:0]           cur_code;
   logic [WIDTH-1:0]           cur_data;
   logic                       accept;
   logic                       advance;
   logic                       last_phase;

   assign cur_code   = sel_q[phase_q*SEL_W +: SEL_W];
   assign last_phase = (phase_q == 3'(NUM_PHASE-1));
   assign busy       = (state_q == RUN);

   // Code 0 and any code beyond NUM_SRC both fall through to zero.
   always_comb begin
      cur_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cur_code == SEL_W'(i+1)) cur_data = src_bus[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      accept  = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
               phase_d = 3'd0;
            end
         end
         RUN: begin
            if (!stall) begin
               advance = 1'b1;
               if (last_phase) begin
                  state_d = IDLE;
                  phase_d = 3'd0;
               end else begin
                  phase_d = phase_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         phase_q <= 3'd0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Stall cycles leave out_data/out_phase untouched so the last operand stays visible.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_phase <= 3'd0;
         done      <= 1'b0;
      end else begin
         if (accept) sel_q <= sel_vec;
         out_valid <= advance;
         done      <= advance && last_phase;
         if (advance) begin
            out_data  <= cur_data;
            out_phase <= phase_q;
         end
      end
   end

`ifdef OPSEQ_SELERR_EN
   logic err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (advance && (cur_code > SEL_W'(NUM_SRC))) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed self-checking bench for operand_sequencer with default parameters.
module tb_operand_sequencer;

   localparam int WIDTH     = 32;
   localparam int NUM_SRC   = 8;
   localparam int SEL_W     = 4;
   localparam int NUM_PHASE = 3;
`ifdef OPSEQ_SELERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic                       clock;
   logic                       reset_n;
   logic                       start;
   logic [NUM_PHASE*SEL_W-1:0] sel_vec;
   logic [NUM_SRC*WIDTH-1:0]   src_bus;
   logic                       stall;
   logic                       busy;
   logic [WIDTH-1:0]           out_data;
   logic                       out_valid;
   logic [2:0]                 out_phase;
   logic                       done;
   logic                       err;

   int check_count = 0;
   int error_count = 0;

   operand_sequencer #(
      .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .NUM_PHASE(NUM_PHASE)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .sel_vec(sel_vec),
      .src_bus(src_bus), .stall(stall), .busy(busy), .out_data(out_data),
      .out_valid(out_valid), .out_phase(out_phase), .done(done), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive inputs, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic st, input logic [NUM_PHASE*SEL_W-1:0] sv, input logic stl);
      start   = st;
      sel_vec = sv;
      stall   = stl;
      @(posedge clock);
      #1;
   endtask

   task automatic checkPhase(input string tag, input logic [WIDTH-1:0] data, input logic [2:0] ph,
                             input logic dn, input logic bsy);
      checkOutput({tag, " valid"}, 64'(out_valid), 64'(1'b1));
      checkOutput({tag, " data"},  64'(out_data),  64'(data));
      checkOutput({tag, " phase"}, 64'(out_phase), 64'(ph));
      checkOutput({tag, " done"},  64'(done),      64'(dn));
      checkOutput({tag, " busy"},  64'(busy),      64'(bsy));
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      sel_vec = '0;
      stall   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) src_bus[i*WIDTH +: WIDTH] = 32'h1000 + 32'(i);
      #12;
      checkOutput("reset busy",  64'(busy),      64'(0));
      checkOutput("reset data",  64'(out_data),  64'(0));
      checkOutput("reset valid", 64'(out_valid), 64'(0));
      checkOutput("reset phase", 64'(out_phase), 64'(0));
      checkOutput("reset done",  64'(done),      64'(0));
      checkOutput("reset err",   64'(err),       64'(0));
      reset_n = 1'b1;
      applyStimulus(0, '0, 0);

      $display("[TB] basic sequence");
      applyStimulus(1, 12'h052, 0);
      checkOutput("basic busy rise", 64'(busy), 64'(1));
      checkOutput("basic no valid yet", 64'(out_valid), 64'(0));
      applyStimulus(0, 12'h000, 0);
      checkPhase("basic p0", 32'h1001, 3'd0, 1'b0, 1'b1);
      applyStimulus(0, 12'h000, 0);
      checkPhase("basic p1", 32'h1004, 3'd1, 1'b0, 1'b1);
      applyStimulus(0, 12'h000, 0);
      checkPhase("basic p2", 32'h0, 3'd2, 1'b1, 1'b0);
      checkOutput("basic err", 64'(err), 64'(0));
      applyStimulus(0, 12'h000, 0);
      checkOutput("basic valid drop", 64'(out_valid), 64'(0));
      checkOutput("basic done drop",  64'(done),      64'(0));

      $display("[TB] stall");
      applyStimulus(1, 12'h052, 0);
      applyStimulus(0, 12'h000, 0);
      checkPhase("stall p0", 32'h1001, 3'd0, 1'b0, 1'b1);
      for (int s = 0; s < 2; s++) begin
         applyStimulus(0, 12'h000, 1);
         checkOutput("stall valid", 64'(out_valid), 64'(0));
         checkOutput("stall data hold", 64'(out_data), 64'(32'h1001));
         checkOutput("stall phase hold", 64'(out_phase), 64'(0));
         checkOutput("stall busy", 64'(busy), 64'(1));
      end
      applyStimulus(0, 12'h000, 0);
      checkPhase("stall p1", 32'h1004, 3'd1, 1'b0, 1'b1);
      applyStimulus(0, 12'h000, 0);
      checkPhase("stall p2", 32'h0, 3'd2, 1'b1, 1'b0);

      $display("[TB] illegal code");
      applyStimulus(1, 12'h1F3, 0);
      applyStimulus(0, 12'h000, 0);
      checkPhase("illegal p0", 32'h1002, 3'd0, 1'b0, 1'b1);
      checkOutput("illegal err before", 64'(err), 64'(0));
      applyStimulus(0, 12'h000, 0);
      checkPhase("illegal p1", 32'h0, 3'd1, 1'b0, 1'b1);
      checkOutput("illegal err set", 64'(err), 64'(ERR_EN));
      applyStimulus(0, 12'h000, 0);
      checkPhase("illegal p2", 32'h1000, 3'd2, 1'b1, 1'b0);
      applyStimulus(0, 12'h000, 0);
      checkOutput("illegal err idle", 64'(err), 64'(ERR_EN));

      $display("[TB] start while busy");
      applyStimulus(1, 12'h052, 0);
      checkOutput("restart err clear", 64'(err), 64'(0));
      applyStimulus(0, 12'h000, 0);
      checkPhase("busy p0", 32'h1001, 3'd0, 1'b0, 1'b1);
      applyStimulus(1, 12'h777, 0);
      checkPhase("busy p1", 32'h1004, 3'd1, 1'b0, 1'b1);
      applyStimulus(1, 12'h777, 0);
      checkPhase("busy p2 start on done", 32'h0, 3'd2, 1'b1, 1'b0);
      applyStimulus(0, 12'h000, 0);
      checkOutput("busy no extra busy", 64'(busy), 64'(0));
      checkOutput("busy no extra valid", 64'(out_valid), 64'(0));
      applyStimulus(0, 12'h000, 0);
      checkOutput("busy still idle", 64'(busy), 64'(0));

      $display("[TB] async reset mid-sequence");
      applyStimulus(1, 12'h052, 0);
      applyStimulus(0, 12'h000, 0);
      checkPhase("areset p0", 32'h1001, 3'd0, 1'b0, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("areset busy",  64'(busy),      64'(0));
      checkOutput("areset data",  64'(out_data),  64'(0));
      checkOutput("areset valid", 64'(out_valid), 64'(0));
      checkOutput("areset phase", 64'(out_phase), 64'(0));
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 12'h000, 0);
         checkOutput("areset no resume valid", 64'(out_valid), 64'(0));
         checkOutput("areset no resume busy",  64'(busy),      64'(0));
      end
      applyStimulus(1, 12'h052, 0);
      applyStimulus(0, 12'h000, 0);
      checkPhase("fresh p0", 32'h1001, 3'd0, 1'b0, 1'b1);
      applyStimulus(0, 12'h000, 0);
      checkPhase("fresh p1", 32'h1004, 3'd1, 1'b0, 1'b1);
      applyStimulus(0, 12'h000, 0);
      checkPhase("fresh p2", 32'h0, 3'd2, 1'b1, 1'b0);

      $display("[TB] live source");
      src_bus[4*WIDTH +: WIDTH] = 32'hA;
      applyStimulus(1, 12'h505, 0);
      applyStimulus(0, 12'h000, 0);
      checkPhase("live p0", 32'hA, 3'd0, 1'b0, 1'b1);
      src_bus[4*WIDTH +: WIDTH] = 32'hB;
      applyStimulus(0, 12'h000, 0);
      checkPhase("live p1", 32'h0, 3'd1, 1'b0, 1'b1);
      applyStimulus(0, 12'h000, 0);
      checkPhase("live p2", 32'hB, 3'd2, 1'b1, 1'b0);
      applyStimulus(0, 12'h000, 0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Multi-phase operand selector for the CPU datapath: on `start` it walks a fixed number of execution phases. In each phase it picks one of `NUM_SRC` register/stack sources using a per-phase select code and presents it as a registered operand. It is the parametrised, self-sequencing successor to the combinational three-phase register-output mux. Phase strobes are generated internally, and the block adds stall, completion and illegal-select signalling.

## Interface
- `WIDTH`, 32, data width of every source and of the output
- `NUM_SRC`, 8, number of selectable sources (1..15)
- `SEL_W`, 4, select code width per phase
- `NUM_PHASE`, 3, phases per sequence (1..8)
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sequence; honoured only in IDLE
- `sel_vec`  in  `NUM_PHASE*SEL_W`  per-phase select codes; phase p is `sel_vec[p*SEL_W +: SEL_W]`, latched on accepted `start`
- `src_bus`  in  `NUM_SRC*WIDTH`  sources; source i is `src_bus[i*WIDTH +: WIDTH]`, sampled live every phase
- `stall`  in  1  freeze the sequence for this cycle
- `busy`  out  1  sequence in progress
- `out_data`  out  `WIDTH`  registered operand
- `out_valid`  out  1  `out_data` updated this cycle (one-cycle pulse per phase)
- `out_phase`  out  3  phase index belonging to `out_data`
- `done`  out  1  one-cycle pulse, coincident with the last phase's `out_valid`
- `err`  out  1  sticky illegal-select flag

## Operation
- States: IDLE, RUN.
- **IDLE:**
  - `busy`=0.
  - `start`=1 latches `sel_vec` into `sel_q`, clears `err`, sets phase counter to 0 and enters RUN.
- **RUN:** `busy`=1.
  - **Stall cycle** (`stall`=1): counter holds, `out_valid`=0, `out_data`/`out_phase` hold.
  - **Non-stall cycle:** the selected source is registered into `out_data`; `out_valid`=1; `out_phase`=counter; the counter increments.
  - **Last phase** (counter = `NUM_PHASE-1`, not stalled): `done`=1 alongside `out_valid`, and the state returns to IDLE.
- **Select decode** (code c of the current phase):
  - c=0 → all-zero.
  - 1 ≤ c ≤ `NUM_SRC` → source c-1.
  - c > `NUM_SRC` → all-zero, plus an error event (see Configuration).
- `start` while in RUN is ignored; `sel_q` is unaffected.
- `start` in the same cycle as `done` is ignored because the state is still RUN. A new sequence can start from the following cycle.
- Sources are not latched at `start`. A source change between phases is visible in later phases.
- **Reset** (async, any time, including mid-sequence): state=IDLE, counter=0, `sel_q`=0, `busy`=0, `out_data`=0, `out_valid`=0, `out_phase`=0, `done`=0, `err`=0. A sequence interrupted by reset does not resume.

## Timing
- `start` sampled at edge t → `busy`=1 after edge t.
- First `out_valid` follows the edge at t+1, i.e. one cycle after `busy` rises.
- With no stalls:
  - phases p=0..NUM_PHASE-1 appear after edges t+1+p;
  - `done` appears after edge t+NUM_PHASE;
  - `busy` falls after the same edge.
- Each stall cycle delays all subsequent phases by exactly one cycle.
- `out_data` reflects `src_bus` as sampled on the cycle before its `out_valid`.
- `err` is set on the same edge as the offending phase's `out_valid`. It stays set until reset or the next accepted `start`.

## Configuration
- Macro `OPSEQ_SELERR_EN`:
  - **Defined:** illegal codes (c > `NUM_SRC`) set sticky `err`, and the sequence continues.
  - **Undefined:** `err` is tied to 0 and no detection logic is built; illegal codes still output zero.

## Test plan
- **Basic sequence** (defaults; srcs i=0..7 hold 0x1000+i; `sel_vec` phases {2,5,0}; `start` pulse): one valid per cycle with `out_data` 0x1001, 0x1004, 0x00000000 and `out_phase` 0,1,2. `done` with phase 2; `busy` high for 3 cycles; `err`=0.
- **Stall:** `stall`=1 for 2 cycles on the cycle phase 1 would register → phase 1 `out_valid` delayed exactly 2 cycles; `out_data` held at the phase-0 value during the stall; `done` 2 cycles late.
- **Illegal code:** phase 1 code 0xF with the macro defined → phase 1 `out_data`=0, `err`=1 from that edge through IDLE. Next `start` clears `err`. Without the macro, `err` stays 0.
- **Start while busy:** `start` re-asserted mid-sequence with different `sel_vec` → outputs follow the original codes; no extra sequence.
- **Async reset mid-sequence:** `reset_n` low between phase 0 and phase 1 → all outputs 0 immediately; no further `out_valid`; a fresh `start` after release runs a full 3-phase sequence.
- **Live source:** `src_bus` source 4 changes 0xA→0xB between phase 0 and phase 2, both phases selecting code 5 → phase 0 outputs 0xA, phase 2 outputs 0xB.
